// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and gray-code helpers for the dual-clock FIFO controllers.
// Contents: DEF_ADDR_W/DEF_DATA_W/DEF_PTR_W defaults, bin2gray, gray2bin.
// The helpers work on 32-bit zero-extended values; callers truncate to pointer width.
package fifo_pkg;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_PTR_W = DEF_ADDR_W + 1;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_out_skid.sv
// fifo_out_skid: 2-entry output buffer presenting RAM read data on a valid/ready stream.
// Ports: i_clk, i_rst_n (async active-low), i_push/i_push_data (word arriving from RAM),
//        i_ready (downstream accept), o_occ (0..2 buffered words), o_valid, o_data (head).
module fifo_out_skid
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_ready,
  output logic [1:0]        o_occ,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  logic [DATA_W-1:0] r_head, r_tail;
  logic [1:0]        r_occ;
  logic              w_pop;
  assign o_valid = r_occ != 2'd0;
  assign o_data  = r_head;
  assign o_occ   = r_occ;
  assign w_pop   = o_valid & i_ready;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ  <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_occ <= r_occ + 2'(i_push) - 2'(w_pop);
      // head takes the tail on a pop from two entries, otherwise the incoming word
      if (w_pop || (r_occ == 2'd0 && i_push)) r_head <= (r_occ == 2'd2) ? r_tail : i_push_data;
      // a push lands in the tail only when one word remains after any pop
      if (i_push && (r_occ - 2'(w_pop)) == 2'd1) r_tail <= i_push_data;
    end
  end
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the dual-clock FIFO (read clock domain only).
// Ports: rd_clk, rd_rst_n (async active-low), rq2_wr_ptr (synchronised gray write pointer),
//        rd_ptr (registered gray read pointer), rd_empty, mem_rd_en/rd_addr (RAM read port),
//        mem_rd_data (RAM data, one cycle after mem_rd_en), out_data/out_valid/out_ready stream.
// Option: define FIFO_RD_CTRL_LEVEL_EN to add rd_level, the registered count of words still in RAM.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic [ADDR_W:0]   rq2_wr_ptr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic              rd_empty,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
`ifdef FIFO_RD_CTRL_LEVEL_EN
  output logic [ADDR_W:0]   rd_level,
`endif
  input  logic              out_ready
);
  localparam int PTR_W = ADDR_W + 1;
  logic [PTR_W-1:0] r_rbin, w_rbin_nxt;
  logic             r_pend;
  logic [1:0]       w_occ;
  logic [2:0]       w_load;
  logic             w_accept, w_issue;
  assign rd_empty   = rd_ptr == rq2_wr_ptr;
  assign w_accept   = out_valid & out_ready;
  // words buffered or in flight after this cycle's accept; keep at most two
  assign w_load     = 3'(w_occ) + 3'(r_pend) - 3'(w_accept);
  assign w_issue    = !rd_empty && w_load < 3'd2;
  assign mem_rd_en  = w_issue;
  assign rd_addr    = r_rbin[ADDR_W-1:0];
  assign w_rbin_nxt = r_rbin + PTR_W'(1);
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_rbin <= '0;
      rd_ptr <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        r_rbin <= w_rbin_nxt;
        rd_ptr <= PTR_W'(bin2gray(32'(w_rbin_nxt)));
      end
    end
  end
`ifdef FIFO_RD_CTRL_LEVEL_EN
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) rd_level <= '0;
    else rd_level <= PTR_W'(gray2bin(32'(rq2_wr_ptr))) - r_rbin;
  end
`endif
  fifo_out_skid #(.DATA_W(DATA_W)) u_skid (
    .i_clk       (rd_clk),
    .i_rst_n     (rd_rst_n),
    .i_push      (r_pend),
    .i_push_data (mem_rd_data),
    .i_ready     (out_ready),
    .o_occ       (w_occ),
    .o_valid     (out_valid),
    .o_data      (out_data)
  );
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: randomized scoreboard bench for fifo_rd_ctrl against a word-count model.
module tb_fifo_rd_ctrl;
  localparam int AW = 3, DW = 8, PW = AW + 1;
  logic          rd_clk = 1'b0, rd_rst_n = 1'b0, out_ready = 1'b0;
  logic [PW-1:0] rq2_wr_ptr = '0, rd_ptr;
  logic          rd_empty, mem_rd_en, out_valid, a;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] mem_rd_data, out_data, first;
`ifdef FIFO_RD_CTRL_LEVEL_EN
  logic [AW:0]   rd_level;
`endif
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] exp_q [$];
  int n_cmp = 0, n_bad = 0, wtot = 0, icnt = 0, acc = 0, i1 = 0, i2 = 0;

  fifo_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .rd_clk      (rd_clk),
    .rd_rst_n    (rd_rst_n),
    .rq2_wr_ptr  (rq2_wr_ptr),
    .rd_ptr      (rd_ptr),
    .rd_empty    (rd_empty),
    .mem_rd_en   (mem_rd_en),
    .rd_addr     (rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
`ifdef FIFO_RD_CTRL_LEVEL_EN
    .rd_level    (rd_level),
`endif
    .out_ready   (out_ready)
  );

  always #5 rd_clk = ~rd_clk;
  always @(posedge rd_clk) if (mem_rd_en) mem_rd_data <= ram[rd_addr];

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] x;
    x = PW'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [DW-1:0] v);
    ram[AW'(wtot)] = v;
    exp_q.push_back(v);
    wtot++;
    rq2_wr_ptr = gray(wtot);
  endtask

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    wtot = 0; icnt = 0; acc = 0; i1 = 0; i2 = 0;
  endtask

  // Model: icnt reads issued, acc words accepted, wtot words written; a read's data
  // becomes visible two cycles after its issue cycle, at most two words outstanding.
  always @(negedge rd_clk) begin
    if (rd_rst_n) begin
      a = out_valid && out_ready;
      chk("rd_ptr", 32'(rd_ptr), 32'(gray(icnt)));
      chk("rd_empty", 32'(rd_empty), 32'(icnt == wtot));
      chk("out_valid", 32'(out_valid), 32'(i2 > acc));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(icnt != wtot && (icnt - acc - int'(a)) < 2));
      if (mem_rd_en) begin
        chk("rd_addr", 32'(rd_addr), 32'(icnt % 8));
        icnt++;
      end
      if (a) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out_data: got unexpected word %0h, expected none", out_data);
        end else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        acc++;
      end
      i2 = i1;
      i1 = icnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("rst rd_ptr", 32'(rd_ptr), 32'h0);
    chk("rst rd_empty", 32'(rd_empty), 32'h1);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst mem_rd_en", 32'(mem_rd_en), 32'h0);
    chk("rst out_data", 32'(out_data), 32'h0);
    rd_rst_n = 1'b1;
    out_ready = 1'b1;
    wr(8'hA5);
    repeat (4) step();
    chk("single rd_ptr", 32'(rd_ptr), 32'h1);
    chk("single rd_empty", 32'(rd_empty), 32'h1);
    out_ready = 1'b0;
    first = 8'($urandom);
    wr(first);
    repeat (4) wr(8'($urandom));
    repeat (6) step();
    chk("bp rd_ptr", 32'(rd_ptr), 32'(4'b0010));
    chk("bp out_data", 32'(out_data), 32'(first));
    out_ready = 1'b1;
    repeat (6) step();
    for (int c = 0; c < 1500; c++) begin
      int ph, n;
      step();
      ph = c / 300;
      out_ready = (ph == 0 || ph == 2) ? 1'b1 : (ph == 3) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      n = (ph == 0) ? 1 : $urandom_range(0, 3);
      for (int k = 0; k < n; k++) if (exp_q.size() < 8) wr(8'($urandom));
    end
    out_ready = 1'b0;
    repeat (4) wr(8'($urandom));
    repeat (4) step();
    #1;
    rd_rst_n = 1'b0;
    rq2_wr_ptr = '0;
    model_clear();
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'h0);
    chk("mid rst rd_ptr", 32'(rd_ptr), 32'h0);
    chk("mid rst mem_rd_en", 32'(mem_rd_en), 32'h0);
    chk("mid rst rd_empty", 32'(rd_empty), 32'h1);
    repeat (2) step();
    rd_rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();
    repeat (6) wr(8'($urandom));
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) step();
    chk("drain remaining", 32'(exp_q.size()), 32'h0);
    repeat (3) step();
    chk("final rd_empty", 32'(rd_empty), 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller of the dual-clock FIFO. Runs entirely in the read clock domain.
- Takes the write pointer after it has been synchronised into the read domain (gray) and owns the read pointer (binary and gray).
- Detects empty, issues read strobes and addresses to the FIFO RAM (1-cycle synchronous read), and presents data on a valid/ready stream through a 2-entry output buffer. Full throughput: 1 word/cycle.

Parameters:
- ADDR_W, 3, RAM address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
- DATA_W, 8, data word width.

Ports:
- rd_clk  in  1  read-domain clock
- rd_rst_n  in  1  asynchronous, active-low reset
- rq2_wr_ptr  in  ADDR_W+1  write pointer, gray, already synchronised into rd_clk domain
- rd_ptr  out  ADDR_W+1  read pointer, gray, registered; goes to the read-to-write synchroniser
- rd_empty  out  1  FIFO empty (combinational compare of registered values)
- mem_rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address (binary read pointer LSBs)
- mem_rd_data  in  DATA_W  RAM read data, valid the cycle after mem_rd_en
- out_data  out  DATA_W  head-of-buffer data
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept

Behaviour:
- Reset (async assert, sync release): rbin=0, rd_ptr=0, pend=0, occ=0, buffer cleared; out_valid=0, out_data=0, mem_rd_en=0, rd_empty=1 while rq2_wr_ptr=0.
- Reset mid-operation clears everything. In-flight RAM data is discarded.
- rd_empty = (rd_ptr == rq2_wr_ptr), compared over all ADDR_W+1 bits.
- accept = out_valid & out_ready.
- issue = !rd_empty & ((occ + pend - accept) < 2).
- mem_rd_en = issue; rd_addr = rbin[ADDR_W-1:0].
- On issue: rbin <= rbin+1 (mod 2^(ADDR_W+1)); rd_ptr <= bin2gray(rbin+1), giving a single-bit change per step.
- pend <= issue. When pend=1, mem_rd_data is written into the buffer tail the same cycle.
- occ counts 0..2 buffered words; next occ = occ + pend - accept. occ never exceeds 2.
- out_valid = (occ != 0). out_data = head entry. Head pops on accept. A simultaneous write and pop are both honoured.
- Latency: rq2_wr_ptr changes at edge k with buffer empty -> mem_rd_en high in cycle k -> out_valid high after edge k+2.
- Steady stream with out_ready=1: occ=1, pend=1, one issue per cycle, no bubbles.
- Backpressure: out_ready=0 -> at most 2 reads outstanding/buffered, then issue stops. Data is never dropped or reordered.
- Wrap-around: address LSBs wrap at 2^ADDR_W; the MSB toggles. Empty compare remains correct across the wrap.
- rq2_wr_ptr jumping by more than 1 (clock ratio) is legal; words drain one per issue.

Optional Feature:
- Macro: FIFO_RD_CTRL_LEVEL_EN.
- Defined: adds output rd_level [ADDR_W:0] = gray2bin(rq2_wr_ptr) - rbin, registered (1-cycle lag), reset 0. Counts words still in RAM and excludes the output buffer.
- Undefined: port and logic absent; no other behaviour change.

Decomposition:
- Shared package fifo_pkg: ADDR_W/DATA_W defaults, PTR_W = ADDR_W+1, functions bin2gray and gray2bin. The write-side controller reuses them.
- One natural sub-module: fifo_out_skid, the 2-entry buffer with occ counter, push/pop and out_valid/out_data.
- Pointer, empty and issue logic stay in the top.

Test Plan:
- Reset: hold rd_rst_n=0, rq2_wr_ptr=0 -> rd_ptr=0, rd_empty=1, out_valid=0, mem_rd_en=0; assert rd_rst_n mid-clock -> outputs clear immediately.
- Single word: rq2_wr_ptr 0000->0001, RAM[0]=0xA5, out_ready=1 -> one mem_rd_en pulse with rd_addr=0. out_valid high for one cycle 2 edges later with out_data=0xA5. rd_ptr=0001, rd_empty=1.
- Stream: rq2_wr_ptr=1100 (bin 8), RAM[i]=i, out_ready=1 -> 8 consecutive mem_rd_en on addresses 0..7. out_valid high 8 consecutive cycles carrying 0..7. Final rd_ptr=1100.
- Backpressure: 5 words available, out_ready=0 -> exactly 2 reads, rd_ptr=0011, out_data=RAM[0] held. Raise out_ready -> remaining 3 delivered in order with no gap.
- Wrap: pointers pre-advanced to bin 14, rq2_wr_ptr -> gray(2)=0011 -> reads at addresses 6,7,0,1. rd_ptr ends at 0011, rd_empty=1.
- Reset mid-stream: rd_rst_n low while pend=1, occ=2 -> out_valid=0, buffer empty, rd_ptr=0. In-flight data not presented after release.
